// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one mono sample per frame, duplicated to both channels,
// saturated to 24 bits, with a one-deep holding register and underrun flag.
module audio_i2s_tx #(
    parameter int BCLK_DIV = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic signed [31:0] sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               mute,
    output logic               bclk,
    output logic               lrclk,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun
);

    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [DW-1:0] r_div;
    logic [4:0]  r_slot;
    logic        r_bclk;
    logic        r_lrclk;
    logic        r_sdata;
    logic        r_fs;
    logic        r_under;
    logic        r_hold_full;
    logic [23:0] r_hold;
    logic [23:0] r_word;

    logic        w_tc;
    logic        w_fall;
    logic        w_frame_end;
    logic        w_load;
    logic        w_accept;
    logic [4:0]  w_slot_nxt;
    logic        w_bit;
    logic [23:0] w_sat;

    always_comb begin
        w_tc        = (r_state == S_RUN) && (r_div == DIV_TC);
        w_fall      = w_tc && r_bclk;
        w_frame_end = w_fall && (r_slot == 5'd31) && r_lrclk;
        w_slot_nxt  = r_slot + 5'd1;
        w_accept    = sample_valid && !r_hold_full;
        w_load      = enable && ((r_state == S_IDLE) || w_frame_end);
    end

    // Slot n carries word bit 24-n: the one-BCLK I2S delay after lrclk.
    always_comb begin
        w_bit = 1'b0;
        if (w_slot_nxt >= 5'd1 && w_slot_nxt <= 5'd24) begin
            w_bit = r_word[5'd24 - w_slot_nxt];
        end
    end

    always_comb begin
        w_sat = sample_in[23:0];
        if (sample_in > 32'sd8388607) begin
            w_sat = 24'h7FFFFF;
        end else if (sample_in < -32'sd8388608) begin
            w_sat = 24'h800000;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (enable) w_state_nxt = S_RUN;
            S_RUN:  if (w_frame_end && !enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_slot      <= '0;
            r_bclk      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
            r_fs        <= 1'b0;
            r_under     <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_word      <= '0;
        end else begin
            r_fs <= w_load;

            if (w_accept) begin
                r_hold      <= w_sat;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            // An empty holding register leaves the previous word in place.
            if (w_load) begin
                if (mute) begin
                    r_word <= '0;
                end else if (r_hold_full) begin
                    r_word <= r_hold;
                end
            end

            if (w_load && !r_hold_full) begin
                r_under <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_under <= 1'b0;
            end

            if (r_state == S_IDLE || w_state_nxt == S_IDLE) begin
                r_div   <= '0;
                r_slot  <= '0;
                r_bclk  <= 1'b0;
                r_lrclk <= 1'b0;
                r_sdata <= 1'b0;
            end else begin
                if (w_tc) begin
                    r_div  <= '0;
                    r_bclk <= ~r_bclk;
                end else begin
                    r_div <= r_div + 1'b1;
                end
                if (w_fall) begin
                    r_slot  <= w_slot_nxt;
                    r_sdata <= w_bit;
                    if (r_slot == 5'd31) begin
                        r_lrclk <= ~r_lrclk;
                    end
                end
            end
        end
    end

    assign sample_ready = ~r_hold_full;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign frame_start  = r_fs;
    assign underrun     = r_under;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: decodes the serial stream per frame and compares
// it against a frame-level model of the holding register and word reuse.
module tb_audio_i2s_tx;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic signed [31:0] sample_in;
    logic               sample_valid;
    logic               sample_ready;
    logic               mute;
    logic               bclk;
    logic               lrclk;
    logic               sdata;
    logic               frame_start;
    logic               underrun;

    int n_asrt = 0;
    int n_fail = 0;

    bit          m_full;
    logic [23:0] m_hold;
    logic [23:0] m_last;
    bit          m_under;

    audio_i2s_tx #(.BCLK_DIV(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] sat(input logic [31:0] s);
        longint v;
        v = longint'($signed(s));
        if (v > 64'sd8388607) return 24'h7FFFFF;
        if (v < -64'sd8388608) return 24'h800000;
        return s[23:0];
    endfunction

    task automatic model_load(input bit m);
        logic [23:0] w;
        if (m_full) begin
            w = m ? 24'h0 : m_hold;
            m_full = 0;
        end else begin
            w = m ? 24'h0 : m_last;
            m_under = 1;
        end
        m_last = w;
    endtask

    task automatic model_reset();
        m_full = 0;
        m_hold = '0;
        m_last = '0;
        m_under = 0;
    endtask

    // Starts on the negedge where frame_start is seen; ends 256 clk later.
    task automatic step(input bit give, input logic [31:0] s, input bit m);
        logic [23:0] wl, wr;
        int pad, lrerr, lrat, k;
        bit prev;
        chk("ready_after_load", sample_ready, 1);
        mute = m;
        if (give) begin
            sample_in = s;
            sample_valid = 1'b1;
        end
        wl = '0; wr = '0; pad = 0; lrerr = 0; lrat = -1; k = 0;
        prev = bclk;
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (give && c == 1) begin
                m_full = 1;
                m_hold = sat(s);
            end
            if (lrat < 0 && lrclk) lrat = c;
            if (bclk && !prev && k < 64) begin
                if (lrclk !== (k >= 32)) lrerr++;
                if ((k % 32) >= 1 && (k % 32) <= 24) begin
                    if (k < 32) wl[24 - (k % 32)] = sdata;
                    else        wr[24 - (k % 32)] = sdata;
                end else if (sdata !== 1'b0) begin
                    pad++;
                end
                k++;
            end
            prev = bclk;
        end
        chk("bclk_rises", k, 64);
        chk("left_word", wl, m_last);
        chk("right_word", wr, m_last);
        chk("pad_zero", pad, 0);
        chk("lrclk_slot", lrerr, 0);
        chk("lrclk_at_128", lrat, 128);
        chk("frame_start", frame_start, 1);
        model_load(m);
        chk("underrun", underrun, m_under);
    endtask

    initial begin
        int toggles;
        logic b254;
        model_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        mute = 1'b0;
        sample_in = '0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_bclk", bclk, 0);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_under", underrun, 0);
        chk("rst_ready", sample_ready, 1);

        sample_in = 32'sd4660;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        m_full = 1;
        m_hold = sat(32'sd4660);
        chk("ready_full", sample_ready, 0);

        enable = 1'b1;
        @(negedge clk);
        chk("first_fs", frame_start, 1);
        chk("first_bclk", bclk, 0);
        model_load(1'b0);

        step(1'b1, 32'sd10000000, 1'b0);
        step(1'b1, -32'sd10000000, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b1, 32'sd100, 1'b1);
        step(1'b1, 32'sd321, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 4) == 0);
        end

        // enable drops at left slot 10 with a sample pending
        sample_in = 32'sd777;
        sample_valid = 1'b1;
        b254 = 1'b0;
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (c == 1) begin
                m_full = 1;
                m_hold = sat(32'sd777);
            end
            if (c == 40) enable = 1'b0;
            if (c == 254) b254 = bclk;
        end
        chk("drop_bclk_running", b254, 1);
        chk("drop_no_fs", frame_start, 0);
        chk("drop_lrclk", lrclk, 0);
        chk("drop_sdata", sdata, 0);
        toggles = 0;
        repeat (4) begin
            @(negedge clk);
            if (bclk !== 1'b0) toggles++;
        end
        m_under = 0;
        chk("idle_bclk", toggles, 0);
        chk("idle_under", underrun, m_under);
        chk("idle_hold_kept", sample_ready, 0);

        enable = 1'b1;
        @(negedge clk);
        chk("restart_fs", frame_start, 1);
        model_load(1'b0);
        chk("restart_ready", sample_ready, 1);
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        enable = 1'b0;
        sample_in = 32'sd55;
        sample_valid = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        sample_valid = 1'b0;
        model_reset();
        chk("mid_rst_bclk", bclk, 0);
        chk("mid_rst_lrclk", lrclk, 0);
        chk("mid_rst_sdata", sdata, 0);
        chk("mid_rst_fs", frame_start, 0);
        chk("mid_rst_under", underrun, 0);
        chk("mid_rst_ready", sample_ready, 1);

        enable = 1'b1;
        @(negedge clk);
        chk("post_rst_fs", frame_start, 1);
        model_load(1'b0);
        chk("post_rst_under", underrun, m_under);
        step(1'b0, 32'sd0, 1'b0);
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 8, meaning clk cycles per BCLK half-period (>=2).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge (one clock domain).
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  run the serializer.
REQ-005 SHALL have port sample_in  input  32 signed  mono sample from the oscillator sound_out.
REQ-006 SHALL have port sample_valid  input  1  sample_in is valid this cycle.
REQ-007 SHALL have port sample_ready  output  1  holding register is empty and accepts a sample.
REQ-008 SHALL have port mute  input  1  transmit zero words.
REQ-009 SHALL have port bclk  output  1  I2S bit clock.
REQ-010 SHALL have port lrclk  output  1  I2S word select: 0 = left, 1 = right.
REQ-011 SHALL have port sdata  output  1  I2S serial data, MSB first.
REQ-012 SHALL have port frame_start  output  1  one-clk pulse when a frame word is loaded.
REQ-013 SHALL have port underrun  output  1  sticky flag: a frame was loaded with no new sample.

Function
REQ-014 SHALL use states IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE only at the end of right slot 31 with enable=0.
REQ-015 In IDLE, SHALL drive bclk=0, lrclk=0 and sdata=0, and SHALL hold the divider and slot counters at 0.
REQ-016 In RUN, SHALL count the divider 0..BCLK_DIV-1 and toggle bclk at the terminal count; bclk period = 2*BCLK_DIV clk.
REQ-017 SHALL advance a 5-bit slot counter (0..31, wrapping) on each bclk falling toggle; lrclk SHALL toggle on the falling toggle where the slot wraps 31->0.
REQ-018 A frame SHALL be 64 BCLK: left slots 0..31, then right slots 0..31.
REQ-019 Per channel, SHALL drive sdata=0 at slot 0, word bit (24-slot) at slots 1..24, and 0 at slots 25..31; sdata SHALL change only on bclk falling toggles (one-BCLK I2S delay after lrclk).
REQ-020 SHALL convert sample_in to 24 bits by saturation: >8388607 -> 24'h7FFFFF; <-8388608 -> 24'h800000; otherwise the low 24 bits.
REQ-021 SHALL load the frame word at the IDLE->RUN transition and at each right-slot-31 -> left-slot-0 wrap; left and right SHALL carry the same word.
REQ-022 When the holding register is full at a load, SHALL load its converted value and mark the holding register empty.
REQ-023 When the holding register is empty at a load, SHALL reload the previous word (0 after reset) and set underrun.
REQ-024 When mute=1 at a load, SHALL load 24'h0; the holding register SHALL still be consumed.
REQ-025 SHALL pulse frame_start for the single clk of each load.
REQ-026 Handshake: sample_ready = NOT hold_full; a sample SHALL be accepted when sample_valid && sample_ready, with hold_full set on the next clk.
REQ-027 Simultaneous accept and load with hold empty: SHALL follow REQ-023 for the load and SHALL store the new sample (hold_full=1).
REQ-028 Simultaneous accept and load with hold full: not possible, since sample_ready=0.
REQ-029 underrun SHALL clear only on reset or while in IDLE.
REQ-030 If enable drops mid-frame, SHALL finish the current frame before entering IDLE; the holding register SHALL be preserved.

Reset
REQ-031 While reset_n=0 at a clk edge, SHALL set: state IDLE, bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, hold empty (sample_ready=1), last word 0, all counters 0.
REQ-032 sample_valid SHALL be ignored in cycles where reset_n=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with no completion of the frame.

Verification (BCLK_DIV=2: bclk period 4 clk, frame 256 clk)
REQ-034 Give sample 32'sd4660 and raise enable -> frame_start at the first RUN clk; left slots 1..24 = 24'h001234; right slot data identical; lrclk toggles every 128 clk.
REQ-035 Give sample 32'sd10000000 -> transmitted word 24'h7FFFFF; give sample -32'sd10000000 -> word 24'h800000.
REQ-036 Give no sample before the second load -> previous word repeats and underrun=1 until enable=0 (IDLE).
REQ-037 Set mute=1 with sample 32'sd100 pending -> word 0 transmitted and sample_ready returns to 1 after the load.
REQ-038 Drop enable at left slot 10 -> frame completes through right slot 31, then bclk, lrclk and sdata = 0.
REQ-039 Assert reset_n=0 mid-frame for 1 clk -> all outputs at reset values on the next clk, and sample_ready=1.
